// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns PC_F, drives the req/gnt/rvalid instruction-memory
// handshake and loads the IF/ID register (pc_d, instr_d, valid_d, exc_adel_d).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic        valid_d,
    output logic        exc_adel_d,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] buf_word, buf_word_nx;
    logic        buf_exc, buf_exc_nx;
    logic [31:0] pc_f_nx, pc_d_nx, instr_d_nx;
    logic        valid_d_nx, exc_d_nx;
    logic        pc_legal, complete, cpl_exc;
    logic [31:0] cpl_word;

    assign pc_legal  = (pc_f[1:0] == 2'b00) && (pc_f >= IMEM_BASE) && (pc_f <= IMEM_LIMIT);
    assign imem_addr = pc_f;
    // Gated by reset so no request is visible while the stage is held in reset.
    assign imem_req  = reset && (state == S_REQ) && pc_legal && !flush;

    always_comb begin
        complete    = 1'b0;
        cpl_word    = '0;
        cpl_exc     = 1'b0;
        fetch_busy  = 1'b0;
        state_nx    = state;
        pc_f_nx     = pc_f;
        pc_d_nx     = pc_d;
        instr_d_nx  = instr_d;
        valid_d_nx  = valid_d;
        exc_d_nx    = exc_adel_d;
        buf_word_nx = buf_word;
        buf_exc_nx  = buf_exc;

        case (state)
            S_REQ: begin
                fetch_busy = pc_legal;
                if (!pc_legal) begin
                    complete = 1'b1;
                    cpl_exc  = 1'b1;
                end else if (imem_gnt) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                fetch_busy = !imem_rvalid;
                if (imem_rvalid) begin
                    complete = 1'b1;
                    cpl_word = imem_rdata;
                end
            end
            S_HOLD: begin
                complete = 1'b1;
                cpl_word = buf_word;
                cpl_exc  = buf_exc;
            end
            S_DRAIN: begin
                fetch_busy = 1'b1;
                if (imem_rvalid) state_nx = S_REQ;
            end
            default: state_nx = S_REQ;
        endcase

        if (flush) begin
            pc_d_nx     = pc_f;
            instr_d_nx  = '0;
            valid_d_nx  = 1'b0;
            exc_d_nx    = 1'b0;
            pc_f_nx     = next_pc;
            buf_word_nx = '0;
            buf_exc_nx  = 1'b0;
            // An rvalid arriving in the flush cycle retires the abandoned request.
            if ((state == S_WAIT || state == S_DRAIN) && !imem_rvalid)
                state_nx = S_DRAIN;
            else
                state_nx = S_REQ;
        end else if (complete) begin
            if (stall) begin
                buf_word_nx = cpl_word;
                buf_exc_nx  = cpl_exc;
                state_nx    = S_HOLD;
            end else begin
                pc_d_nx    = pc_f;
                instr_d_nx = cpl_word;
                valid_d_nx = 1'b1;
                exc_d_nx   = cpl_exc;
                pc_f_nx    = next_pc;
                state_nx   = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_REQ;
            pc_f       <= RESET_PC;
            pc_d       <= '0;
            instr_d    <= '0;
            valid_d    <= 1'b0;
            exc_adel_d <= 1'b0;
            buf_word   <= '0;
            buf_exc    <= 1'b0;
        end else begin
            state      <= state_nx;
            pc_f       <= pc_f_nx;
            pc_d       <= pc_d_nx;
            instr_d    <= instr_d_nx;
            valid_d    <= valid_d_nx;
            exc_adel_d <= exc_d_nx;
            buf_word   <= buf_word_nx;
            buf_exc    <= buf_exc_nx;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run checked
// against a flag-based transaction model of the fetch stage.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        stall, flush, imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr, pc_f, pc_d, instr_d;
    logic        valid_d, exc_adel_d, fetch_busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: IF/ID image, PC, one pending-request flag, abandon flag, buffer.
    logic [31:0] m_pc_f, m_pc_d, m_instr, m_buf_word;
    logic        m_valid, m_exc, m_pending, m_discard, m_buf_full, m_buf_exc;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_3000),
        .IMEM_BASE (32'h0000_3000),
        .IMEM_LIMIT(32'h0000_6FFC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc_f       (pc_f),
        .pc_d       (pc_d),
        .instr_d    (instr_d),
        .valid_d    (valid_d),
        .exc_adel_d (exc_adel_d),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFC);
    endfunction

    function automatic logic exp_req();
        return !m_pending && !m_buf_full && legal(m_pc_f) && !flush;
    endfunction

    function automatic logic exp_busy();
        if (m_pending) return m_discard || !imem_rvalid;
        return !m_buf_full && legal(m_pc_f);
    endfunction

    task automatic model_reset();
        m_pc_f = 32'h3000; m_pc_d = '0; m_instr = '0; m_valid = 1'b0; m_exc = 1'b0;
        m_pending = 1'b0; m_discard = 1'b0; m_buf_full = 1'b0; m_buf_exc = 1'b0; m_buf_word = '0;
    endtask

    task automatic model_edge();
        logic        have;
        logic [31:0] w;
        logic        e;
        have = 1'b0; w = '0; e = 1'b0;
        if (flush) begin
            m_pc_d = m_pc_f; m_instr = '0; m_valid = 1'b0; m_exc = 1'b0;
            m_pc_f = next_pc; m_buf_full = 1'b0;
            if (m_pending && !imem_rvalid) m_discard = 1'b1;
            else begin m_pending = 1'b0; m_discard = 1'b0; end
        end else begin
            if (m_buf_full) begin
                have = 1'b1; w = m_buf_word; e = m_buf_exc;
            end else if (m_pending) begin
                if (imem_rvalid) begin
                    if (!m_discard) begin have = 1'b1; w = imem_rdata; end
                    m_pending = 1'b0; m_discard = 1'b0;
                end
            end else if (!legal(m_pc_f)) begin
                have = 1'b1; e = 1'b1;
            end else if (imem_gnt) begin
                m_pending = 1'b1;
            end
            if (have) begin
                if (stall) begin
                    m_buf_full = 1'b1; m_buf_word = w; m_buf_exc = e;
                end else begin
                    m_pc_d = m_pc_f; m_instr = w; m_valid = 1'b1; m_exc = e;
                    m_pc_f = next_pc; m_buf_full = 1'b0;
                end
            end
        end
    endtask

    task automatic drive(input logic f, input logic s, input logic g, input logic rv,
                         input logic [31:0] rd, input logic [31:0] np);
        @(negedge clk);
        flush = f; stall = s; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; next_pc = np;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 0; stall = 0; imem_gnt = 0; imem_rvalid = 0;
        imem_rdata = '0; next_pc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({pc_f, pc_d, instr_d, valid_d, exc_adel_d, imem_req} !==
            {32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: pc_f=%h pc_d=%h instr=%h v=%b exc=%b req=%b, need 3000/0/0/0/0/0",
                     pc_f, pc_d, instr_d, valid_d, exc_adel_d, imem_req);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_fetch();
        drive(0, 0, 1, 0, 32'h0, 32'h3004);
        n_cmp++;
        if ({imem_req, imem_addr, fetch_busy} !== {1'b1, 32'h3000, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_req: req=%b addr=%h busy=%b, need 1/3000/1", imem_req, imem_addr, fetch_busy);
        end
        tick();
        drive(0, 0, 0, 1, 32'h3C011234, 32'h3004);
        n_cmp++;
        if (fetch_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_rvalid: busy=%b, need 0", fetch_busy);
        end
        tick();
        n_cmp++;
        if ({pc_d, instr_d, valid_d, exc_adel_d, pc_f} !== {32'h3000, 32'h3C011234, 1'b1, 1'b0, 32'h3004}) begin
            n_bad++;
            $display("FAIL basic_ifid: pc_d=%h instr=%h v=%b exc=%b pc_f=%h, need 3000/3c011234/1/0/3004",
                     pc_d, instr_d, valid_d, exc_adel_d, pc_f);
        end
    endtask

    task automatic test_stall_hold();
        drive(0, 0, 1, 0, 32'h0, 32'h3008);
        tick();
        drive(0, 1, 0, 1, 32'hAABB_CCDD, 32'h3008);
        tick();
        n_cmp++;
        if ({pc_d, instr_d, pc_f} !== {32'h3000, 32'h3C011234, 32'h3004}) begin
            n_bad++;
            $display("FAIL stall_hold_ifid: pc_d=%h instr=%h pc_f=%h, need 3000/3c011234/3004", pc_d, instr_d, pc_f);
        end
        drive(0, 1, 1, 0, 32'h0, 32'h3008);
        n_cmp++;
        if ({imem_req, fetch_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL hold_outputs: req=%b busy=%b, need 0/0", imem_req, fetch_busy);
        end
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h3008);
        tick();
        n_cmp++;
        if ({pc_d, instr_d, valid_d, pc_f} !== {32'h3004, 32'hAABB_CCDD, 1'b1, 32'h3008}) begin
            n_bad++;
            $display("FAIL stall_release: pc_d=%h instr=%h v=%b pc_f=%h, need 3004/aabbccdd/1/3008",
                     pc_d, instr_d, valid_d, pc_f);
        end
    endtask

    task automatic test_flush_drain();
        drive(0, 0, 1, 0, 32'h0, 32'h300C);
        tick();
        drive(1, 0, 0, 0, 32'h0, 32'h4180);
        tick();
        n_cmp++;
        if ({valid_d, pc_d, instr_d, pc_f} !== {1'b0, 32'h3008, 32'h0, 32'h4180}) begin
            n_bad++;
            $display("FAIL flush_bubble: v=%b pc_d=%h instr=%h pc_f=%h, need 0/3008/0/4180", valid_d, pc_d, instr_d, pc_f);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 32'h0, 32'h4184);
            n_cmp++;
            if ({imem_req, fetch_busy} !== 2'b01) begin
                n_bad++;
                $display("FAIL drain_wait: req=%b busy=%b, need 0/1", imem_req, fetch_busy);
            end
            tick();
        end
        drive(0, 0, 0, 1, 32'hFFFF_FFFF, 32'h4184);
        n_cmp++;
        if (fetch_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_busy: busy=%b, need 1", fetch_busy);
        end
        tick();
        n_cmp++;
        if ({instr_d, valid_d, pc_f} !== {32'h0, 1'b0, 32'h4180}) begin
            n_bad++;
            $display("FAIL drain_discard: instr=%h v=%b pc_f=%h, need 0/0/4180", instr_d, valid_d, pc_f);
        end
        drive(0, 0, 1, 0, 32'h0, 32'h3002);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4180}) begin
            n_bad++;
            $display("FAIL after_drain_req: req=%b addr=%h, need 1/4180", imem_req, imem_addr);
        end
        tick();
        drive(0, 0, 0, 1, 32'h1234_5678, 32'h3002);
        tick();
    endtask

    task automatic test_illegal();
        drive(0, 0, 1, 0, 32'h0, 32'h7000);
        n_cmp++;
        if ({pc_f, imem_req, fetch_busy} !== {32'h3002, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL misaligned_noreq: pc_f=%h req=%b busy=%b, need 3002/0/0", pc_f, imem_req, fetch_busy);
        end
        tick();
        n_cmp++;
        if ({pc_d, instr_d, exc_adel_d, valid_d, pc_f} !== {32'h3002, 32'h0, 1'b1, 1'b1, 32'h7000}) begin
            n_bad++;
            $display("FAIL misaligned_exc: pc_d=%h instr=%h exc=%b v=%b pc_f=%h, need 3002/0/1/1/7000",
                     pc_d, instr_d, exc_adel_d, valid_d, pc_f);
        end
        drive(0, 0, 1, 0, 32'h0, 32'h3010);
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL range_noreq: req=%b, need 0", imem_req);
        end
        tick();
        n_cmp++;
        if ({pc_d, instr_d, exc_adel_d, valid_d, pc_f} !== {32'h7000, 32'h0, 1'b1, 1'b1, 32'h3010}) begin
            n_bad++;
            $display("FAIL range_exc: pc_d=%h instr=%h exc=%b v=%b pc_f=%h, need 7000/0/1/1/3010",
                     pc_d, instr_d, exc_adel_d, valid_d, pc_f);
        end
    endtask

    task automatic test_flush_stall_hold();
        drive(0, 0, 1, 0, 32'h0, 32'h3014);
        tick();
        drive(0, 1, 0, 1, 32'h0BAD_F00D, 32'h3014);
        tick();
        drive(1, 1, 0, 0, 32'h0, 32'h5000);
        tick();
        n_cmp++;
        if ({valid_d, instr_d, pc_d, pc_f} !== {1'b0, 32'h0, 32'h3010, 32'h5000}) begin
            n_bad++;
            $display("FAIL flush_over_stall: v=%b instr=%h pc_d=%h pc_f=%h, need 0/0/3010/5000",
                     valid_d, instr_d, pc_d, pc_f);
        end
        drive(0, 0, 0, 0, 32'h0, 32'h5004);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h5000}) begin
            n_bad++;
            $display("FAIL flush_hold_to_req: req=%b addr=%h, need 1/5000", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        drive(0, 0, 1, 0, 32'h0, 32'h5004);
        tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({pc_f, pc_d, instr_d, valid_d, exc_adel_d, imem_req} !==
            {32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: pc_f=%h pc_d=%h instr=%h v=%b exc=%b req=%b, need 3000/0/0/0/0/0",
                     pc_f, pc_d, instr_d, valid_d, exc_adel_d, imem_req);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        drive(0, 0, 0, 1, 32'hDEAD_BEEF, 32'h3004);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h3000}) begin
            n_bad++;
            $display("FAIL post_reset_req: req=%b addr=%h, need 1/3000", imem_req, imem_addr);
        end
        tick();
        n_cmp++;
        if ({valid_d, instr_d, pc_f} !== {1'b0, 32'h0, 32'h3000}) begin
            n_bad++;
            $display("FAIL stray_rvalid: v=%b instr=%h pc_f=%h, need 0/0/3000", valid_d, instr_d, pc_f);
        end
    endtask

    task automatic test_random();
        logic        f, s, g, rv, er, eb;
        logic [31:0] rd, np;
        for (int i = 0; i < 3000; i++) begin
            f  = ($urandom % 10) == 0;
            s  = ($urandom % 4) == 0;
            g  = ($urandom % 2) == 0;
            rv = m_pending && (($urandom % 3) == 0);
            rd = $urandom;
            case ($urandom % 8)
                0, 1, 2, 3, 4: np = m_pc_f + 32'd4;
                5:             np = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
                6:             np = $urandom;
                default:       np = 32'h3001 + ($urandom_range(0, 32'h0FFF) << 2);
            endcase
            drive(f, s, g, rv, rd, np);
            er = exp_req();
            eb = exp_busy();
            n_cmp++;
            if ({imem_req, fetch_busy, (er ? imem_addr : 32'h0)} !== {er, eb, (er ? m_pc_f : 32'h0)}) begin
                n_bad++;
                if (n_bad < 20)
                    $display("FAIL rand_comb[%0d]: req=%b busy=%b addr=%h, need %b/%b/%h",
                             i, imem_req, fetch_busy, imem_addr, er, eb, m_pc_f);
            end
            tick();
            n_cmp++;
            if ({pc_f, pc_d, instr_d, valid_d, exc_adel_d} !== {m_pc_f, m_pc_d, m_instr, m_valid, m_exc}) begin
                n_bad++;
                if (n_bad < 20)
                    $display("FAIL rand_regs[%0d]: pc_f=%h pc_d=%h instr=%h v=%b exc=%b, need %h/%h/%h/%b/%b",
                             i, pc_f, pc_d, instr_d, valid_d, exc_adel_d, m_pc_f, m_pc_d, m_instr, m_valid, m_exc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_flush_drain();
        test_illegal();
        test_flush_stall_hold();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Fetch stage of the pipelined MIPS core: holds PC_F, issues instruction-memory reads over a req/gnt/rvalid handshake, and loads the IF/ID register with PC_D and instruction.
- Consumes next_pc from the next-PC unit.
- Supplies pc_f and pc_d back to the next-PC unit, and supplies the D-stage instruction.
- Branches resolve in D with one delay slot, so a fetch completes and D advances on the same edge.

Parameters:
RESET_PC, 32'h0000_3000, PC_F value after reset
IMEM_BASE, 32'h0000_3000, lowest legal fetch address
IMEM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
next_pc  in  32  PC to fetch after the current one, from next-PC unit
stall  in  1  hazard stall: hold IF/ID; completed fetch is buffered
flush  in  1  synchronous redirect: bubble IF/ID, abandon current fetch, PC_F<=next_pc
imem_req  out  1  read request valid
imem_addr  out  32  read address (= pc_f while imem_req)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid (one per granted request, >=1 cycle after gnt)
imem_rdata  in  32  instruction word
pc_f  out  32  current fetch PC
pc_d  out  32  IF/ID PC
instr_d  out  32  IF/ID instruction
valid_d  out  1  IF/ID holds a real instruction
exc_adel_d  out  1  IF/ID instruction raised fetch address error
fetch_busy  out  1  no fetch completes this cycle; hazard unit must freeze D

Behaviour:
- Reset (async, while reset=0):
  - pc_f=RESET_PC, pc_d=0, instr_d=0, valid_d=0, exc_adel_d=0.
  - State REQ, buffer cleared, imem_req=0.
- States:
  - REQ: issue. imem_req = legal(pc_f) & !flush. If pc_f is illegal, the fetch completes immediately with instr=0 and exc=1, and no memory request is made.
  - WAIT: request granted, awaiting rvalid.
  - HOLD: instruction buffered while stall=1.
  - DRAIN: awaiting rvalid of an abandoned request; the data is discarded.
- legal(pc) = pc[1:0]==0 & pc>=IMEM_BASE & pc<=IMEM_LIMIT. Unsigned compare, full 32 bits.
- Transitions:
  - REQ & legal & gnt & !flush -> WAIT.
  - REQ & illegal & !flush: completes.
  - WAIT & rvalid: completes with imem_rdata.
  - HOLD: completes with buffered word.
  - Complete & !stall: IF/ID <= {pc_f, word, valid=1, exc}, pc_f<=next_pc, next state REQ.
  - Complete & stall: word/exc into buffer, state HOLD, pc_f unchanged, IF/ID unchanged.
- fetch_busy = 1 in DRAIN, in WAIT without rvalid, and in REQ when legal (even if gnt). Else 0; HOLD is always 0.
- stall=1 holds IF/ID and pc_f in every state. Outstanding requests still complete into the buffer.
- IF/ID changes only on completion & !stall, or on flush. Otherwise it holds; no self-inserted bubble.
- flush has priority over stall and over completion:
  - IF/ID <= {pc_d=pc_f, instr=0, valid=0, exc=0}; pc_f<=next_pc; buffer discarded.
  - REQ: imem_req forced 0 that cycle; stay REQ.
  - WAIT & rvalid same cycle: data discarded -> REQ.
  - WAIT & !rvalid -> DRAIN.
  - HOLD -> REQ.
  - DRAIN: stay DRAIN; pc_f updated.
- DRAIN & rvalid -> REQ, data discarded.
- One outstanding request maximum. imem_addr and imem_req are stable until gnt.
- Reset mid-WAIT/DRAIN: state returns to REQ. A later stray rvalid in REQ is ignored.

Test Plan:
- Reset release, memory grants immediately and returns rvalid next cycle with 0x3C011234, next_pc=pc_f+4 -> imem_addr=0x3000; after completion pc_d=0x3000, instr_d=0x3C011234, valid_d=1, pc_f=0x3004; fetch_busy=1 in REQ and 0 on the rvalid cycle.
- stall=1 across rvalid in WAIT -> state HOLD, IF/ID unchanged, pc_f=0x3004 held. Drop stall -> IF/ID loads buffered word, pc_f<=next_pc on that edge.
- flush while WAIT, rvalid 3 cycles later with 0xFFFFFFFF, next_pc=0x4180 -> valid_d=0 next edge, pc_f=0x4180, DRAIN. Discarded data never reaches instr_d. Next imem_addr=0x4180.
- next_pc=0x3002 (misaligned) -> no imem_req. Next edge: pc_d=0x3002, instr_d=0, exc_adel_d=1, valid_d=1. Repeat with 0x7000 (out of range) -> same response.
- flush and stall asserted together in HOLD -> flush wins: buffer dropped, valid_d=0, pc_f=next_pc, state REQ.
- reset=0 asserted mid-WAIT, async -> outputs immediately at reset values. After release, the first imem_addr=0x3000 and the late rvalid is ignored.
